pck_ejector: RTL

- Receive side of the endpoint packet interface: the destination-end counterpart of the packet injector.
- Accepts flits from the router local output port and reassembles them into packets independently per VC.
- Returns one credit per consumed flit.
- Emits one packet-received pulse per packet carrying source address, class, VC, size, leading data bits and header-to-tail delay.

---
 rtl/pck_ejector.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/pck_ejector.sv
// pck_ejector: destination-end packet receiver. Reassembles flits from the
// router local output port into packets independently per virtual channel,
// returns one credit per consumed flit, and emits one pck_wr pulse per packet
// with source, class, VC, size, leading data bits and header-to-tail delay.
module pck_ejector #(
   parameter int V            = 2,
   parameter int EAw          = 4,
   parameter int DSTPw        = 4,
   parameter int C            = 2,
   parameter int Fpay         = 32,
   parameter int PCK_INJ_Dw   = 64,
   parameter int MAX_PCK_SIZ  = 15,
   localparam int Cw          = (C > 1) ? $clog2(C) : 1,
   localparam int PCK_SIZw    = $clog2(MAX_PCK_SIZ + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [EAw-1:0]        current_e_addr,
   input  logic                  flit_wr,
   input  logic                  flit_hdr,
   input  logic                  flit_tail,
   input  logic [V-1:0]          flit_vc,
   input  logic [Fpay-1:0]       flit_payload,
   output logic [V-1:0]          credit_out,
   output logic                  pck_wr,
   output logic [EAw-1:0]        pck_src_e_addr,
   output logic [Cw-1:0]         pck_class,
   output logic [V-1:0]          pck_vc,
   output logic [PCK_SIZw-1:0]   pck_size,
   output logic [PCK_INJ_Dw-1:0] pck_data,
   output logic [15:0]           pck_h2t_delay,
   output logic                  err_dst,
   output logic                  err_proto
);

   // Header field positions, LSB first: src, dst, destport, class, data.
   localparam int CLS_LSB = 2*EAw + DSTPw;
   localparam int HDR_LSB = CLS_LSB + ((C > 1) ? Cw : 0);
   // Data pointer must be able to hold PCK_INJ_Dw itself (the saturated value).
   localparam int PTRw    = $clog2(PCK_INJ_Dw + 1);
   localparam int HDR_PTR = ((Fpay - HDR_LSB) > PCK_INJ_Dw) ? PCK_INJ_Dw : (Fpay - HDR_LSB);

   typedef enum logic {
      VC_IDLE = 1'b0,
      VC_BUSY = 1'b1
   } vc_state_e;

   // Everything one VC needs to rebuild its current packet.
   typedef struct packed {
      vc_state_e               state;
      logic [EAw-1:0]          src;
      logic [Cw-1:0]           cls;
      logic [PCK_SIZw-1:0]     size;
      logic [PCK_INJ_Dw-1:0]   data;
      logic [PTRw-1:0]         ptr;
      logic [15:0]             delay;
   } vc_ctx_t;

   vc_ctx_t ctx_q [V];
   vc_ctx_t ctx_d [V];

   logic                  accept;
   logic [EAw-1:0]        hdr_src;
   logic [EAw-1:0]        hdr_dst;
   logic [Cw-1:0]         hdr_cls;
   logic [PCK_INJ_Dw-1:0] hdr_data;

   logic [V-1:0]          credit_d;
   logic                  wr_d;
   logic                  edst_d;
   logic                  eproto_d;
   logic [EAw-1:0]        src_d;
   logic [Cw-1:0]         cls_d;
   logic [V-1:0]          vc_d;
   logic [PCK_SIZw-1:0]   size_d;
   logic [PCK_INJ_Dw-1:0] data_d;
   logic [15:0]           delay_d;

   // A flit is consumed only with a one-hot VC; the block never backpressures.
   assign accept   = flit_wr & $onehot(flit_vc);
   assign hdr_src  = flit_payload[EAw-1:0];
   assign hdr_dst  = flit_payload[2*EAw-1:EAw];
   assign hdr_cls  = (C > 1) ? flit_payload[CLS_LSB +: Cw] : '0;
   assign hdr_data = PCK_INJ_Dw'(flit_payload >> HDR_LSB);

   // Per-VC next state, completion capture, credit and error pulses.
   always_comb begin
      // NOTE: every variable driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      credit_d = accept ? flit_vc : '0;
      eproto_d = flit_wr & ~$onehot(flit_vc);
      edst_d   = 1'b0;
      wr_d     = 1'b0;
      src_d    = pck_src_e_addr;
      cls_d    = pck_class;
      vc_d     = pck_vc;
      size_d   = pck_size;
      data_d   = pck_data;
      delay_d  = pck_h2t_delay;

      for (int v = 0; v < V; v++) begin
         ctx_d[v] = ctx_q[v];

         // Open packets age every cycle, saturating.
         if (ctx_q[v].state == VC_BUSY && ctx_q[v].delay != 16'hFFFF) begin
            ctx_d[v].delay = ctx_q[v].delay + 16'd1;
         end

         if (accept && flit_vc[v]) begin
            if (flit_hdr) begin
               // A header always starts a fresh packet; an open one is abandoned.
               if (ctx_q[v].state == VC_BUSY) begin
                  eproto_d = 1'b1;
               end
               if (hdr_dst != current_e_addr) begin
                  edst_d = 1'b1;
               end
               ctx_d[v].src   = hdr_src;
               ctx_d[v].cls   = hdr_cls;
               ctx_d[v].size  = PCK_SIZw'(1);
               ctx_d[v].data  = hdr_data;
               ctx_d[v].ptr   = PTRw'(HDR_PTR);
               ctx_d[v].delay = '0;
               ctx_d[v].state = flit_tail ? VC_IDLE : VC_BUSY;
            end else if (ctx_q[v].state == VC_IDLE) begin
               // Body/tail with no open packet: dropped, credit still returned.
               eproto_d = 1'b1;
            end else begin
               if (ctx_q[v].size != PCK_SIZw'(MAX_PCK_SIZ)) begin
                  ctx_d[v].size = ctx_q[v].size + PCK_SIZw'(1);
               end
               // Bits above the pointer are still zero, so OR-in is a write;
               // anything shifted past the top of the data word is dropped.
               ctx_d[v].data = ctx_q[v].data | (PCK_INJ_Dw'(flit_payload) << ctx_q[v].ptr);
               if ((int'(ctx_q[v].ptr) + Fpay) >= PCK_INJ_Dw) begin
                  ctx_d[v].ptr = PTRw'(PCK_INJ_Dw);
               end else begin
                  ctx_d[v].ptr = ctx_q[v].ptr + PTRw'(Fpay);
               end
               if (flit_tail) begin
                  ctx_d[v].state = VC_IDLE;
               end
            end

            // Tail closes a packet only if one was open (or just opened).
            if (flit_tail && (flit_hdr || ctx_q[v].state == VC_BUSY)) begin
               wr_d    = 1'b1;
               src_d   = ctx_d[v].src;
               cls_d   = ctx_d[v].cls;
               vc_d    = flit_vc;
               size_d  = ctx_d[v].size;
               data_d  = ctx_d[v].data;
               delay_d = ctx_d[v].delay;
            end
         end
      end
   end

   // Per-VC context registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the context array is plain flops, not RAM, and reset must
         // discard partial packets, so every entry is cleared.
         for (int v = 0; v < V; v++) begin
            ctx_q[v] <= '0;
         end
      end else begin
         // NOTE: state uses non-blocking assignment so all flops update
         // together on the edge regardless of statement order.
         for (int v = 0; v < V; v++) begin
            ctx_q[v] <= ctx_d[v];
         end
      end
   end

   // Registered outputs: pulses for credit/pck_wr/errors, held packet fields.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         credit_out     <= '0;
         pck_wr         <= 1'b0;
         pck_src_e_addr <= '0;
         pck_class      <= '0;
         pck_vc         <= '0;
         pck_size       <= '0;
         pck_data       <= '0;
         pck_h2t_delay  <= '0;
         err_dst        <= 1'b0;
         err_proto      <= 1'b0;
      end else begin
         credit_out     <= credit_d;
         pck_wr         <= wr_d;
         pck_src_e_addr <= src_d;
         pck_class      <= cls_d;
         pck_vc         <= vc_d;
         pck_size       <= size_d;
         pck_data       <= data_d;
         pck_h2t_delay  <= delay_d;
         err_dst        <= edst_d;
         err_proto      <= eproto_d;
      end
   end

endmodule
